// File: rtl/tt_extract3_if.sv
// rtl/tt_extract3_if.sv - control, result and stimulus bundle for the truth-table characterizer
interface tt_extract3_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic [7:0] tt_code;
    logic       match;

    modport master (
        output start, abort, expected, dut_out,
        input  stim, busy, done, tt_code, match
    );

    modport slave (
        input  start, abort, expected, dut_out,
        output stim, busy, done, tt_code, match
    );
endinterface

// File: rtl/tt_extract3.sv
// rtl/tt_extract3.sv - steps a 3-input block through rows 000..111 and assembles its 8-bit truth-table code
module tt_extract3 #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tt_extract3_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       row;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [7:0]       exp_q;
    logic [7:0]       sh_next;
    logic [7:0]       code_q;
    logic             match_q;
    logic             row_end;

    assign row_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));

    // Row r lands in bit 7-r so row 000 ends up as the MSB of the code.
    always_comb begin
        sh_next = shreg;
        sh_next[3'd7 - row] = bus.dut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SETTLE;
            SETTLE: begin
                if (bus.abort)                        state_nx = IDLE;
                else if (row_end && (row == 3'd7))    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= 3'd0;
            cnt     <= '0;
            shreg   <= 8'h00;
            exp_q   <= 8'h00;
            code_q  <= 8'h00;
            match_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_q <= bus.expected;
                        shreg <= 8'h00;
                        row   <= 3'd0;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        row <= 3'd0;
                        cnt <= '0;
                    end else if (row_end) begin
                        shreg <= sh_next;
                        cnt   <= '0;
                        if (row == 3'd7) begin
                            // The final sample goes straight into the result alongside the earlier rows.
                            code_q  <= sh_next;
                            match_q <= (sh_next == exp_q);
                            row     <= 3'd0;
                        end else begin
                            row <= row + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stim    = (state == SETTLE) ? row : 3'd0;
    assign bus.busy    = (state == SETTLE);
    assign bus.done    = (state == DONE);
    assign bus.tt_code = code_q;
    assign bus.match   = match_q;
endmodule

// File: tb/tb_tt_extract3.sv
// tb/tb_tt_extract3.sv - scoreboard bench for tt_extract3 with settle times of 4 and 1
module tb_tt_extract3;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] model4 = 2'd0;

    typedef struct {
        logic [7:0] tt;
        logic       m;
        int         at;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    tt_extract3_if b4 ();
    tt_extract3_if b1 ();

    tt_extract3 #(.SETTLE_CYCLES(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    tt_extract3 #(.SETTLE_CYCLES(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Block-under-test models: 0 -> out=1 at rows 100 and 111, 1 -> constant 1; second unit sees out=in3.
    assign b4.dut_out = (model4 == 2'd0) ? ((b4.stim == 3'd4) || (b4.stim == 3'd7)) : 1'b1;
    assign b1.dut_out = b1.stim[0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && b4.done) begin
            if (q4.size() == 0) begin
                check("s4 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("s4 tt_code", {24'd0, b4.tt_code}, {24'd0, e.tt});
                check("s4 match", {31'd0, b4.match}, {31'd0, e.m});
                check("s4 done cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.done) begin
            if (q1.size() == 0) begin
                check("s1 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("s1 tt_code", {24'd0, b1.tt_code}, {24'd0, e.tt});
                check("s1 match", {31'd0, b1.match}, {31'd0, e.m});
                check("s1 done cycle", cyc, e.at);
            end
        end
    end

    task automatic run4(input logic [7:0] exp_code, input logic [7:0] tt, input logic m,
                        input logic [7:0] prev_tt, input int restart_at);
        exp_t e;
        @(negedge clk);
        b4.start = 1'b1;
        b4.expected = exp_code;
        e.tt = tt; e.m = m; e.at = cyc + 1 + 32;
        q4.push_back(e);
        @(negedge clk);
        b4.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("s4 stim", {29'd0, b4.stim}, i / 4);
            check("s4 busy", {31'd0, b4.busy}, 32'd1);
            if (i == 16) check("s4 tt_code held", {24'd0, b4.tt_code}, {24'd0, prev_tt});
            if (i == restart_at) b4.start = 1'b1;
            if (i == restart_at + 1) b4.start = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        check("s4 busy after done", {31'd0, b4.busy}, 32'd0);
        check("s4 stim after done", {29'd0, b4.stim}, 32'd0);
    endtask

    initial begin
        b4.start = 1'b0; b4.abort = 1'b0; b4.expected = 8'h00;
        b1.start = 1'b0; b1.abort = 1'b0; b1.expected = 8'h00;

        #2 rst_n = 1'b0;
        #1;
        check("reset stim", {29'd0, b4.stim}, 32'd0);
        check("reset busy", {31'd0, b4.busy}, 32'd0);
        check("reset done", {31'd0, b4.done}, 32'd0);
        check("reset tt_code", {24'd0, b4.tt_code}, 32'd0);
        check("reset match", {31'd0, b4.match}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        model4 = 2'd0;
        run4(8'h09, 8'h09, 1'b1, 8'h00, -10);
        run4(8'h90, 8'h09, 1'b0, 8'h09, -10);
        model4 = 2'd1;
        run4(8'hFF, 8'hFF, 1'b1, 8'h09, -10);
        model4 = 2'd0;
        run4(8'h09, 8'h09, 1'b1, 8'hFF, 10);

        // Abort during row 5: no done, results untouched.
        @(negedge clk);
        b4.start = 1'b1;
        b4.expected = 8'h00;
        @(negedge clk);
        b4.start = 1'b0;
        repeat (21) @(negedge clk);
        check("abort stim row5", {29'd0, b4.stim}, 32'd5);
        b4.abort = 1'b1;
        @(negedge clk);
        b4.abort = 1'b0;
        check("abort busy", {31'd0, b4.busy}, 32'd0);
        check("abort stim", {29'd0, b4.stim}, 32'd0);
        check("abort done", {31'd0, b4.done}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort tt_code kept", {24'd0, b4.tt_code}, 32'h09);
        check("abort match kept", {31'd0, b4.match}, 32'd1);

        // Asynchronous reset mid-run, between edges.
        @(negedge clk);
        b4.start = 1'b1;
        b4.expected = 8'h09;
        @(negedge clk);
        b4.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, b4.busy}, 32'd0);
        check("midrst stim", {29'd0, b4.stim}, 32'd0);
        check("midrst tt_code", {24'd0, b4.tt_code}, 32'd0);
        check("midrst match", {31'd0, b4.match}, 32'd0);
        check("midrst done", {31'd0, b4.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run4(8'h09, 8'h09, 1'b1, 8'h00, -10);

        // Single-cycle settle: out = in3.
        begin
            exp_t e;
            @(negedge clk);
            b1.start = 1'b1;
            b1.expected = 8'h55;
            e.tt = 8'h55; e.m = 1'b1; e.at = cyc + 1 + 8;
            q1.push_back(e);
            @(negedge clk);
            b1.start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check("s1 stim", {29'd0, b1.stim}, i);
                check("s1 busy", {31'd0, b1.busy}, 32'd1);
                @(negedge clk);
            end
            @(negedge clk);
            check("s1 busy after done", {31'd0, b1.busy}, 32'd0);
        end

        repeat (5) @(negedge clk);
        check("s4 pending done count", q4.size(), 32'd0);
        check("s1 pending done count", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
